// File: rtl/rgbled_pwm_sequencer_if.sv
// rgbled_pwm_sequencer_if
//   Configuration link between the rgbled register bank (master) and the
//   PWM sequencer (slave).
//   cfg_enable      live run enable
//   cfg_mode        00 static, 01 blink, 10 fade, 11 static
//   cfg_color       {R,G,B} duty values
//   cfg_prescale    clock cycles per PWM tick, minus 1
//   cfg_step_period PWM periods per blink half / fade step (0 acts as 1)
//   cfg_update      commit request pulse
//   update_done     commit acknowledge pulse (slave -> master)
interface rgbled_pwm_sequencer_if #(
   parameter int PWM_BITS   = 8,
   parameter int PRESCALE_W = 16,
   parameter int STEP_W     = 16
);
   logic                    cfg_enable;
   logic [1:0]              cfg_mode;
   logic [3*PWM_BITS-1:0]   cfg_color;
   logic [PRESCALE_W-1:0]   cfg_prescale;
   logic [STEP_W-1:0]       cfg_step_period;
   logic                    cfg_update;
   logic                    update_done;

   modport master (
      output cfg_enable, cfg_mode, cfg_color, cfg_prescale, cfg_step_period, cfg_update,
      input  update_done
   );

   modport slave (
      input  cfg_enable, cfg_mode, cfg_color, cfg_prescale, cfg_step_period, cfg_update,
      output update_done
   );
endinterface

// File: rtl/rgbled_pwm_sequencer.sv
// rgbled_pwm_sequencer
//   Three-channel PWM driver for the RGB LED pads with static, blink and
//   triangular fade modes. Configuration is shadowed and only committed on a
//   PWM period boundary (or on enable rise) so a period is never disturbed.
// Ports
//   ACLK, ARESETN   clock, async active-low reset
//   cfg             slave side of rgbled_pwm_sequencer_if (config + update_done)
//   period_tick     1-cycle pulse after every PWM period boundary
//   state_o         FSM state readback
//   led_r/g/b       registered PWM outputs
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_IDLE      | disabled, counters held at 0, LEDs off
// ST_STATIC    | duty = shadow colour
// ST_BLINK_ON  | duty = shadow colour until the next step event
// ST_BLINK_OFF | duty = 0 until the next step event
// ST_FADE_UP   | brightness +1 per step event, turns at MAX
// ST_FADE_DOWN | brightness -1 per step event, turns at 0
module rgbled_pwm_sequencer #(
   parameter int PWM_BITS   = 8,
   parameter int PRESCALE_W = 16,
   parameter int STEP_W     = 16
) (
   input  logic                         ACLK,
   input  logic                         ARESETN,
   rgbled_pwm_sequencer_if.slave        cfg,
   output logic                         period_tick,
   output logic [2:0]                   state_o,
   output logic                         led_r,
   output logic                         led_g,
   output logic                         led_b
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_STATIC    = 3'd1,
      ST_BLINK_ON  = 3'd2,
      ST_BLINK_OFF = 3'd3,
      ST_FADE_UP   = 3'd4,
      ST_FADE_DOWN = 3'd5
   } state_t;

   localparam logic [PWM_BITS-1:0] MAX_V  = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] LAST_V = {{(PWM_BITS-1){1'b1}}, 1'b0};

   typedef logic [2:0][PWM_BITS-1:0] rgb_t;

   state_t                state_q, state_d;
   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic [PWM_BITS-1:0]   pwm_q, pwm_d;
   logic [STEP_W-1:0]     step_q, step_d;
   logic [PWM_BITS-1:0]   bright_q, bright_d;
   rgb_t                  duty_q, duty_d;
   rgb_t                  sh_color_q, sh_color_d;
   logic [PRESCALE_W-1:0] sh_prescale_q, sh_prescale_d;
   logic [STEP_W-1:0]     sh_step_q, sh_step_d;
   logic                  pending_q, pending_d;
   logic [2:0]            led_q, led_d;
   logic                  update_done_q, update_done_d;
   logic                  period_tick_q, period_tick_d;

   rgb_t                  cfg_color_v;
   logic                  tick, boundary, commit, step_evt;
   state_t                entry_state;

   assign cfg_color_v = cfg.cfg_color;

   // c*(b+1) >> PWM_BITS: exact c at b=MAX, 0 at b=0
   function automatic logic [PWM_BITS-1:0] fade_scale(input logic [PWM_BITS-1:0] c,
                                                      input logic [PWM_BITS-1:0] b);
      logic [2*PWM_BITS-1:0] prod;
      prod = {{PWM_BITS{1'b0}}, c} * {{PWM_BITS{1'b0}}, b} + {{PWM_BITS{1'b0}}, c};
      return prod[2*PWM_BITS-1:PWM_BITS];
   endfunction

   function automatic logic [PWM_BITS-1:0] duty_of(input state_t s,
                                                   input logic [PWM_BITS-1:0] c,
                                                   input logic [PWM_BITS-1:0] b);
      case (s)
         ST_STATIC, ST_BLINK_ON:  return c;
         ST_FADE_UP, ST_FADE_DOWN: return fade_scale(c, b);
         default:                 return '0;
      endcase
   endfunction

   // step counter runs down to 0; a period count of 0 behaves as 1
   function automatic logic [STEP_W-1:0] step_reload(input logic [STEP_W-1:0] s);
      return (s == '0) ? '0 : s - 1'b1;
   endfunction

   always_comb begin
      case (cfg.cfg_mode)
         2'b01:   entry_state = ST_BLINK_ON;
         2'b10:   entry_state = ST_FADE_UP;
         default: entry_state = ST_STATIC;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      pre_d         = pre_q;
      pwm_d         = pwm_q;
      step_d        = step_q;
      bright_d      = bright_q;
      duty_d        = duty_q;
      sh_color_d    = sh_color_q;
      sh_prescale_d = sh_prescale_q;
      sh_step_d     = sh_step_q;
      pending_d     = pending_q;
      led_d         = '0;
      update_done_d = 1'b0;
      period_tick_d = 1'b0;
      commit        = 1'b0;
      step_evt      = 1'b0;
      tick          = (pre_q == '0);
      boundary      = tick && (pwm_q == LAST_V);

      if (!cfg.cfg_enable) begin
         state_d   = ST_IDLE;
         pre_d     = '0;
         pwm_d     = '0;
         step_d    = '0;
         pending_d = 1'b0;
      end else if (state_q == ST_IDLE) begin
         commit = 1'b1;
      end else begin
         for (int i = 0; i < 3; i++) led_d[i] = (pwm_q < duty_q[i]);
         pre_d = tick ? sh_prescale_q : pre_q - 1'b1;
         if (tick) pwm_d = (pwm_q == LAST_V) ? '0 : pwm_q + 1'b1;
         if (boundary) begin
            period_tick_d = 1'b1;
            if (pending_q || cfg.cfg_update) begin
               commit = 1'b1;
            end else begin
               step_evt = (step_q == '0);
               step_d   = step_evt ? step_reload(sh_step_q) : step_q - 1'b1;
               if (step_evt) begin
                  case (state_q)
                     ST_BLINK_ON:  state_d = ST_BLINK_OFF;
                     ST_BLINK_OFF: state_d = ST_BLINK_ON;
                     ST_FADE_UP: begin
                        if (bright_q != MAX_V) bright_d = bright_q + 1'b1;
                        if (bright_d == MAX_V) state_d = ST_FADE_DOWN;
                     end
                     ST_FADE_DOWN: begin
                        if (bright_q != '0) bright_d = bright_q - 1'b1;
                        if (bright_d == '0) state_d = ST_FADE_UP;
                     end
                     default: ;
                  endcase
               end
               for (int i = 0; i < 3; i++) duty_d[i] = duty_of(state_d, sh_color_q[i], bright_d);
            end
         end else if (cfg.cfg_update) begin
            pending_d = 1'b1;
         end
      end

      // commit overrides the counter/FSM updates above
      if (commit) begin
         sh_color_d    = cfg_color_v;
         sh_prescale_d = cfg.cfg_prescale;
         sh_step_d     = cfg.cfg_step_period;
         state_d       = entry_state;
         bright_d      = '0;
         pre_d         = cfg.cfg_prescale;
         pwm_d         = '0;
         step_d        = step_reload(cfg.cfg_step_period);
         pending_d     = 1'b0;
         update_done_d = 1'b1;
         for (int i = 0; i < 3; i++) duty_d[i] = duty_of(entry_state, cfg_color_v[i], '0);
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q       <= ST_IDLE;
         pre_q         <= '0;
         pwm_q         <= '0;
         step_q        <= '0;
         bright_q      <= '0;
         duty_q        <= '0;
         sh_color_q    <= '0;
         sh_prescale_q <= '0;
         sh_step_q     <= '0;
         pending_q     <= 1'b0;
         led_q         <= '0;
         update_done_q <= 1'b0;
         period_tick_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pre_q         <= pre_d;
         pwm_q         <= pwm_d;
         step_q        <= step_d;
         bright_q      <= bright_d;
         duty_q        <= duty_d;
         sh_color_q    <= sh_color_d;
         sh_prescale_q <= sh_prescale_d;
         sh_step_q     <= sh_step_d;
         pending_q     <= pending_d;
         led_q         <= led_d;
         update_done_q <= update_done_d;
         period_tick_q <= period_tick_d;
      end
   end

   assign cfg.update_done = update_done_q;
   assign period_tick     = period_tick_q;
   assign state_o         = state_q;
   assign led_r           = led_q[2];
   assign led_g           = led_q[1];
   assign led_b           = led_q[0];

endmodule

// File: tb/tb_rgbled_pwm_sequencer.sv
module tb_rgbled_pwm_sequencer;
   localparam int PW  = 6;
   localparam int PSW = 16;
   localparam int SW  = 16;
   localparam int MAX = 2**PW - 1;

   logic ACLK = 1'b0;
   logic ARESETN = 1'b0;
   always #5 ACLK = ~ACLK;

   rgbled_pwm_sequencer_if #(.PWM_BITS(PW), .PRESCALE_W(PSW), .STEP_W(SW)) bus();
   logic       period_tick;
   logic [2:0] state_o;
   logic       led_r, led_g, led_b;

   rgbled_pwm_sequencer #(.PWM_BITS(PW), .PRESCALE_W(PSW), .STEP_W(SW)) dut (
      .ACLK        (ACLK),
      .ARESETN     (ARESETN),
      .cfg         (bus),
      .period_tick (period_tick),
      .state_o     (state_o),
      .led_r       (led_r),
      .led_g       (led_g),
      .led_b       (led_b)
   );

   typedef struct { int mode; int r; int g; int b; int pre; int step; } cfg_t;
   typedef struct { int r; int g; int b; int ud; int len; } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   logic mon_clear = 1'b0;

   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: duty of period k after a commit, from the mode rules
   function automatic int exp_duty(input int mode, input int c, input int step, input int k);
      int s, j, ph, b;
      s = (step == 0) ? 1 : step;
      j = k / s;
      if (mode == 1) return (j % 2 == 0) ? c : 0;
      if (mode == 2) begin
         ph = j % (2 * MAX);
         b  = (ph <= MAX) ? ph : 2 * MAX - ph;
         return (c * b + c) >> PW;
      end
      return c;
   endfunction

   function automatic int exp_entry(input int mode);
      if (mode == 1) return 2;
      if (mode == 2) return 4;
      return 1;
   endfunction

   function automatic int rand_col();
      case ($urandom_range(0, 3))
         0:       return 0;
         1:       return MAX;
         default: return int'($urandom_range(0, MAX));
      endcase
   endfunction

   function automatic cfg_t rand_cfg();
      cfg_t c;
      c.mode = int'($urandom_range(0, 3));
      c.r    = rand_col();
      c.g    = rand_col();
      c.b    = rand_col();
      c.pre  = int'($urandom_range(0, 2));
      c.step = int'($urandom_range(0, 3));
      return c;
   endfunction

   function automatic cfg_t mk_cfg(input int mode, input int r, input int g, input int b,
                                   input int pre, input int step);
      cfg_t c;
      c.mode = mode; c.r = r; c.g = g; c.b = b; c.pre = pre; c.step = step;
      return c;
   endfunction

   task automatic apply_cfg(input cfg_t c);
      bus.cfg_mode        = 2'(c.mode);
      bus.cfg_color       = {PW'(c.r), PW'(c.g), PW'(c.b)};
      bus.cfg_prescale    = PSW'(c.pre);
      bus.cfg_step_period = SW'(c.step);
   endtask

   // returns at posedge+1 of cycle c (or immediately if already there)
   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge ACLK);
         #1;
      end
   endtask

   task automatic push_periods(input cfg_t c, input int n, input int first_len_extra,
                               input int ud_first, input int ud_last);
      exp_t e;
      for (int j = 0; j < n; j++) begin
         e.r   = exp_duty(c.mode, c.r, c.step, j) * (c.pre + 1);
         e.g   = exp_duty(c.mode, c.g, c.step, j) * (c.pre + 1);
         e.b   = exp_duty(c.mode, c.b, c.step, j) * (c.pre + 1);
         e.ud  = ((j == 0) ? ud_first : 0) + ((j == n - 1) ? ud_last : 0);
         e.len = MAX * (c.pre + 1) + ((j == 0) ? first_len_extra : 0);
         sb_q.push_back(e);
      end
   endtask

   // Enable with config a for na full periods; optionally request config b
   // during the last of them and run nb periods of b; then drop enable at a
   // random point of the following period.
   task automatic run_seg(input cfg_t a, input int na, input bit upd, input cfg_t b,
                          input int nb, input int want_state);
      int la, lb, lc, e, t, d, tlast;
      la = MAX * (a.pre + 1);
      lb = MAX * (b.pre + 1);
      push_periods(a, na, 1, 1, upd ? 1 : 0);
      if (upd) push_periods(b, nb, 0, 0, 0);
      apply_cfg(a);
      bus.cfg_enable = 1'b1;
      mon_clear      = 1'b1;
      e = cyc;
      wait_until(e + 1);
      mon_clear = 1'b0;
      @(negedge ACLK);
      check("update_done_on_enable", int'(bus.update_done), 1);
      check("entry_state", int'(state_o), exp_entry(a.mode));
      if (upd) begin
         t = e + (na - 1) * la + 1 + int'($urandom_range(0, la - 1));
         wait_until(t);
         apply_cfg(b);
         bus.cfg_update = 1'b1;
         wait_until(t + 1);
         bus.cfg_update = 1'b0;
         if (t + 2 <= e + na * la) begin
            wait_until(t + 2);
            bus.cfg_update = 1'b1;
            wait_until(t + 3);
            bus.cfg_update = 1'b0;
         end
         lc    = lb;
         tlast = e + na * la + nb * lb + 1;
      end else begin
         lc    = la;
         tlast = e + na * la + 1;
      end
      d = tlast + int'($urandom_range(0, lc - 1));
      wait_until(d);
      if (want_state >= 0) begin
         @(negedge ACLK);
         check("state_before_drop", int'(state_o), want_state);
      end
      bus.cfg_enable = 1'b0;
      wait_until(d + 1);
      @(negedge ACLK);
      check("idle_after_drop", int'(state_o), 0);
      check("leds_after_drop", int'({led_r, led_g, led_b}), 0);
      check("tick_after_drop", int'(period_tick), 0);
      wait_until(cyc + 3);
   endtask

   // Monitor: counts LED-high cycles per period window and pops one
   // expected record at every period_tick
   int c_r, c_g, c_b, c_ud, c_len;
   always @(negedge ACLK) begin
      exp_t e;
      if (mon_clear) begin
         c_r = 0; c_g = 0; c_b = 0; c_ud = 0; c_len = 0;
      end else begin
         c_len++;
         c_r  += int'(led_r);
         c_g  += int'(led_g);
         c_b  += int'(led_b);
         c_ud += int'(bus.update_done);
         if (period_tick) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_period: period_tick with no expected period (cycle %0d)", cyc);
            end else begin
               e = sb_q.pop_front();
               check("led_r_high_cycles", c_r, e.r);
               check("led_g_high_cycles", c_g, e.g);
               check("led_b_high_cycles", c_b, e.b);
               check("update_done_count", c_ud, e.ud);
               check("period_length", c_len, e.len);
            end
            c_r = 0; c_g = 0; c_b = 0; c_ud = 0; c_len = 0;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      cfg_t a, b;
      int   e;
      bus.cfg_enable      = 1'b0;
      bus.cfg_update      = 1'b0;
      bus.cfg_mode        = '0;
      bus.cfg_color       = '0;
      bus.cfg_prescale    = '0;
      bus.cfg_step_period = '0;

      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check("reset_leds", int'({led_r, led_g, led_b}), 0);
      check("reset_update_done", int'(bus.update_done), 0);
      check("reset_period_tick", int'(period_tick), 0);
      check("reset_state", int'(state_o), 0);
      @(posedge ACLK);
      #1;
      ARESETN = 1'b1;
      wait_until(cyc + 2);

      // static: R full, G half, B off
      run_seg(mk_cfg(0, MAX, 2**(PW-1), 0, 0, 0), 3, 1'b0, mk_cfg(0, 0, 0, 0, 0, 0), 0, -1);
      // blink step 2, then step 0 (acts as 1)
      run_seg(mk_cfg(1, MAX, 0, 0, 0, 2), 6, 1'b0, mk_cfg(0, 0, 0, 0, 0, 0), 0, -1);
      run_seg(mk_cfg(1, MAX, 0, 0, 0, 0), 4, 1'b0, mk_cfg(0, 0, 0, 0, 0, 0), 0, -1);
      // mid-period colour change on G
      run_seg(mk_cfg(0, 0, 16, 0, 0, 0), 2, 1'b1, mk_cfg(0, 0, 48, 0, 0, 0), 2, -1);
      // full fade up past the peak, dropped while fading down, then re-enabled
      run_seg(mk_cfg(2, MAX, 0, 0, 0, 1), MAX + 3, 1'b0, mk_cfg(0, 0, 0, 0, 0, 0), 0, 5);
      run_seg(mk_cfg(2, MAX, 0, 0, 0, 1), 3, 1'b0, mk_cfg(0, 0, 0, 0, 0, 0), 0, -1);
      // mode change blink -> fade via update
      run_seg(mk_cfg(1, MAX, MAX, 0, 1, 1), 3, 1'b1, mk_cfg(2, MAX, 40, 7, 0, 1), 5, -1);

      for (int i = 0; i < 10; i++) begin
         a = rand_cfg();
         b = rand_cfg();
         run_seg(a, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), b,
                 int'($urandom_range(1, 6)), -1);
      end

      // asynchronous reset mid-period
      apply_cfg(mk_cfg(0, MAX, MAX, MAX, 0, 0));
      bus.cfg_enable = 1'b1;
      mon_clear      = 1'b1;
      e = cyc;
      wait_until(e + 1);
      mon_clear = 1'b0;
      wait_until(e + 40);
      #3;
      ARESETN = 1'b0;
      #1;
      check("async_reset_leds", int'({led_r, led_g, led_b}), 0);
      check("async_reset_update_done", int'(bus.update_done), 0);
      check("async_reset_state", int'(state_o), 0);
      bus.cfg_enable = 1'b0;
      wait_until(cyc + 2);
      ARESETN = 1'b1;
      wait_until(cyc + 2);

      run_seg(mk_cfg(0, 5, MAX, 0, 0, 0), 2, 1'b0, mk_cfg(0, 0, 0, 0, 0, 0), 0, -1);

      wait_until(cyc + 5);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
